// File: rtl/uart_cmd_xcvr.sv
// rtl/uart_cmd_xcvr.sv - full-duplex command-link UART with multi-word TX and checked RX
//
// Purpose:
//   TX side accepts a CMD_WORDS*DATA_BITS command on a valid/ready handshake and
//   sends it as back-to-back frames, most significant word first, each word LSB
//   first. RX side deserialises frames from the rx pin with mid-bit sampling and
//   reports every completed frame with a one-cycle rd_vld pulse plus an error
//   flag covering parity mismatch and a low first stop bit.
//
// Configuration macro:
//   UART_LOOPBACK_EN - when defined the RX synchroniser is fed from the internal
//                      tx line and the rx pin is ignored; tx is still driven.
//
// Ports:
//   clk      in   1          system clock
//   rst_n    in   1          asynchronous active-low reset
//   cmd_in   in   CMD_W      command; [CMD_W-1 -: DATA_BITS] is sent first
//   cmd_vld  in   1          command valid
//   cmd_rdy  out  1          transmitter idle and able to accept a command
//   tx       out  1          serial output, idle high
//   rx       in   1          serial input, asynchronous to clk
//   rd_vld   out  1          one-cycle pulse when rd_data/rd_err update
//   rd_data  out  DATA_BITS  last received word
//   rd_err   out  1          last received word had a parity or stop error

module uart_cmd_xcvr #(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int CMD_WORDS = 2,
    parameter int PARITY    = 1,
    parameter int STOP_BITS = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [CMD_WORDS*DATA_BITS-1:0]   cmd_in,
    input  logic                             cmd_vld,
    output logic                             cmd_rdy,
    output logic                             tx,
    input  logic                             rx,
    output logic                             rd_vld,
    output logic [DATA_BITS-1:0]             rd_data,
    output logic                             rd_err
);

    localparam int CMD_W = CMD_WORDS * DATA_BITS;
    localparam int DIV   = CLK_HZ / BAUD;
    localparam int HALF  = DIV / 2;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int WC_W  = $clog2(CMD_WORDS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(CMD_WORDS - 1);
    // Odd parity: the parity bit is the inverse of the XOR of the data bits.
    localparam logic             PAR_ODD  = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    state_t               tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [IDX_W-1:0]     tx_idx;
    logic [WC_W-1:0]      tx_wcnt;
    logic                 tx_stop_cnt;
    logic [CMD_W-1:0]     cmd_sh;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_par;
    logic                 tx_r;
    logic                 cmd_rdy_r;
    logic                 tx_tick;
    logic [DATA_BITS-1:0] cmd_top;

    assign tx_tick = (tx_cnt == CNT_LAST);
    // Next word to send always sits in the top of the command shift register.
    assign cmd_top = cmd_sh[CMD_W-1 -: DATA_BITS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state    <= S_IDLE;
            tx_cnt      <= '0;
            tx_idx      <= '0;
            tx_wcnt     <= '0;
            tx_stop_cnt <= 1'b0;
            cmd_sh      <= '0;
            tx_data     <= '0;
            tx_par      <= 1'b0;
            tx_r        <= 1'b1;
            cmd_rdy_r   <= 1'b1;
        end else begin
            // Bit-time counter free-runs in every active state and wraps at DIV-1,
            // so each state only has to react to tx_tick.
            if (tx_state != S_IDLE) begin
                tx_cnt <= tx_tick ? '0 : tx_cnt + 1'b1;
            end

            case (tx_state)
                S_IDLE: begin
                    if (cmd_vld && cmd_rdy_r) begin
                        cmd_sh    <= cmd_in;
                        tx_wcnt   <= '0;
                        tx_cnt    <= '0;
                        tx_r      <= 1'b0;
                        cmd_rdy_r <= 1'b0;
                        tx_state  <= S_START;
                    end
                end

                S_START: begin
                    if (tx_tick) begin
                        // Pull the next word out of the command and pre-compute
                        // its parity while the first data bit goes out.
                        tx_data  <= cmd_top;
                        tx_par   <= (^cmd_top) ^ PAR_ODD;
                        cmd_sh   <= cmd_sh << DATA_BITS;
                        tx_r     <= cmd_top[0];
                        tx_idx   <= '0;
                        tx_state <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (tx_tick) begin
                        if (tx_idx == IDX_LAST) begin
                            if (PARITY != 0) begin
                                tx_r     <= tx_par;
                                tx_state <= S_PAR;
                            end else begin
                                tx_r        <= 1'b1;
                                tx_stop_cnt <= 1'b0;
                                tx_state    <= S_STOP;
                            end
                        end else begin
                            tx_idx  <= tx_idx + 1'b1;
                            tx_data <= tx_data >> 1;
                            tx_r    <= tx_data[1];
                        end
                    end
                end

                S_PAR: begin
                    if (tx_tick) begin
                        tx_r        <= 1'b1;
                        tx_stop_cnt <= 1'b0;
                        tx_state    <= S_STOP;
                    end
                end

                S_STOP: begin
                    if (tx_tick) begin
                        if ((STOP_BITS == 2) && !tx_stop_cnt) begin
                            tx_stop_cnt <= 1'b1;
                        end else if (tx_wcnt == WC_LAST) begin
                            cmd_rdy_r <= 1'b1;
                            tx_state  <= S_IDLE;
                        end else begin
                            // Next word starts straight away: no idle gap.
                            tx_wcnt  <= tx_wcnt + 1'b1;
                            tx_r     <= 1'b0;
                            tx_state <= S_START;
                        end
                    end
                end

                default: begin
                    tx_r      <= 1'b1;
                    cmd_rdy_r <= 1'b1;
                    tx_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign tx      = tx_r;
    assign cmd_rdy = cmd_rdy_r;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic rx_src;

`ifdef UART_LOOPBACK_EN
    logic unused_rx;
    assign unused_rx = rx;
    assign rx_src    = tx_r;
`else
    assign rx_src = rx;
`endif

    logic rx_meta;
    logic rx_sync;
    logic rx_prev;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    // All reset high so a reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_src;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    state_t               rx_state;
    logic [CNT_W-1:0]     rx_cnt;
    logic [IDX_W-1:0]     rx_idx;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_par_err;
    logic                 rx_tick;
    logic                 rd_vld_r;
    logic [DATA_BITS-1:0] rd_data_r;
    logic                 rd_err_r;

    // The start bit is sampled after half a bit time to land mid-bit; every
    // later sample is one full bit time after the previous one.
    assign rx_tick = (rx_state == S_START) ? (rx_cnt == CNT_MID) : (rx_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= S_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_sh      <= '0;
            rx_par_err <= 1'b0;
            rd_vld_r   <= 1'b0;
            rd_data_r  <= '0;
            rd_err_r   <= 1'b0;
        end else begin
            rd_vld_r <= 1'b0;

            if (rx_state != S_IDLE) begin
                rx_cnt <= rx_tick ? '0 : rx_cnt + 1'b1;
            end

            case (rx_state)
                S_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_cnt   <= '0;
                        rx_state <= S_START;
                    end
                end

                S_START: begin
                    if (rx_tick) begin
                        // Line back high at mid start bit: glitch, not a frame.
                        if (rx_sync) begin
                            rx_state <= S_IDLE;
                        end else begin
                            rx_idx     <= '0;
                            rx_par_err <= 1'b0;
                            rx_state   <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (rx_tick) begin
                        rx_sh <= {rx_sync, rx_sh[DATA_BITS-1:1]};
                        if (rx_idx == IDX_LAST) begin
                            rx_state <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            rx_idx <= rx_idx + 1'b1;
                        end
                    end
                end

                S_PAR: begin
                    if (rx_tick) begin
                        rx_par_err <= (^rx_sh) ^ rx_sync ^ PAR_ODD;
                        rx_state   <= S_STOP;
                    end
                end

                S_STOP: begin
                    // Only the first stop bit is checked; leaving at its middle
                    // keeps us ready for a back-to-back start bit.
                    if (rx_tick) begin
                        rd_vld_r  <= 1'b1;
                        rd_data_r <= rx_sh;
                        rd_err_r  <= rx_par_err | ~rx_sync;
                        rx_state  <= S_IDLE;
                    end
                end

                default: begin
                    rx_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_vld  = rd_vld_r;
    assign rd_data = rd_data_r;
    assign rd_err  = rd_err_r;

endmodule

// File: tb/tb_uart_cmd_xcvr.sv
// tb/tb_uart_cmd_xcvr.sv - directed scoreboard bench for uart_cmd_xcvr

module tb_uart_cmd_xcvr;

    localparam int DIV   = 434;
    localparam int DB    = 8;
    localparam int NW    = 2;
    localparam int CW    = NW * DB;
    localparam int FB    = 11;
    localparam int NBITS = NW * FB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] cmd_in = '0;
    logic          cmd_vld = 1'b0;
    logic          cmd_rdy;
    logic          tx;
    logic          rx = 1'b1;
    logic          rd_vld;
    logic [DB-1:0] rd_data;
    logic          rd_err;

    int checks = 0;
    int errors = 0;

    logic       tx_q[$];
    logic [8:0] rx_q[$];
    logic [8:0] exp_w;

    uart_cmd_xcvr dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cmd_in  (cmd_in),
        .cmd_vld (cmd_vld),
        .cmd_rdy (cmd_rdy),
        .tx      (tx),
        .rx      (rx),
        .rd_vld  (rd_vld),
        .rd_data (rd_data),
        .rd_err  (rd_err)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RX scoreboard: every rd_vld pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && rd_vld === 1'b1) begin
            if (rx_q.size() == 0) begin
                check("rd_vld_spurious", {31'b0, rd_vld}, 32'd0);
            end else begin
                exp_w = rx_q.pop_front();
                check("rx_word", {23'b0, rd_err, rd_data}, {23'b0, exp_w});
            end
        end
    end

    task automatic rx_frame(input logic [7:0] d, input logic par, input logic stop);
        logic [10:0] bits;
        logic        e;
        bits = {stop, par, d, 1'b0};
        e = ((^{d, par}) != 1'b1) || !stop;
        rx_q.push_back({e, d});
        for (int i = 0; i < 11; i++) begin
            rx = bits[i];
            repeat (DIV) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic rx_drain(input string tag);
        for (int i = 0; i < 3 * DIV && rx_q.size() != 0; i++) @(negedge clk);
        check(tag, rx_q.size(), 0);
    endtask

    task automatic tx_check(input logic [15:0] c);
        int         low_cnt;
        logic [7:0] w;
        low_cnt = 0;
        for (int n = 0; n < NW; n++) begin
            w = c[CW-1-n*DB -: DB];
            tx_q.push_back(1'b0);
            for (int b = 0; b < DB; b++) tx_q.push_back(w[b]);
            tx_q.push_back(~^w);
            tx_q.push_back(1'b1);
`ifdef UART_LOOPBACK_EN
            rx_q.push_back({1'b0, w});
`endif
        end
        check("tx_rdy_before", cmd_rdy, 1);
        cmd_in  = c;
        cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
        cmd_in  = 16'($urandom);
        for (int k = 0; k < NBITS * DIV; k++) begin
            if (!cmd_rdy) low_cnt++;
            if (k % DIV == 0) check("tx_bit_edge", tx, tx_q[0]);
            if (k % DIV == DIV / 2) check("tx_bit_mid", tx, tx_q.pop_front());
            if (k == 1000) begin
                cmd_vld = 1'b1;
                cmd_in  = 16'hFFFF;
            end
            if (k == 1001) cmd_vld = 1'b0;
            @(negedge clk);
        end
        check("tx_rdy_after", cmd_rdy, 1);
        check("tx_rdy_low_cycles", low_cnt, 9548);
        check("tx_idle_after", tx, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_cmd_rdy", cmd_rdy, 1);
        check("reset_rd_vld", rd_vld, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_rd_err", rd_err, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        tx_check(16'hA55A);

`ifndef UART_LOOPBACK_EN
        rx_frame(8'h3C, 1'b1, 1'b1);
        rx_drain("rx_good_3c");
        check("rx_hold_data_3c", rd_data, 8'h3C);
        check("rx_hold_err_3c", rd_err, 0);

        rx_frame(8'h3C, 1'b0, 1'b1);
        rx_frame(8'h81, 1'b1, 1'b0);
        repeat (DIV) @(negedge clk);
        rx_drain("rx_bad_frames");
        check("rx_hold_err_81", rd_err, 1);

        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        rx_frame(8'h55, 1'b1, 1'b1);
        rx_drain("rx_after_glitch");
        check("rx_hold_data_55", rd_data, 8'h55);
`else
        rx_drain("loopback_a55a");
        tx_check(16'h1234);
        rx_drain("loopback_1234");
        check("loopback_hold_data", rd_data, 8'h34);
`endif

        // Reset in the middle of a TX data bit and an RX data bit.
        cmd_in  = 16'hC3A5;
        cmd_vld = 1'b1;
        rx      = 1'b0;
        @(negedge clk);
        cmd_vld = 1'b0;
        repeat (DIV + DIV / 2 + 50) @(negedge clk);
        check("mid_busy_rdy", cmd_rdy, 0);
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        check("mid_reset_tx", tx, 1);
        check("mid_reset_cmd_rdy", cmd_rdy, 1);
        check("mid_reset_rd_vld", rd_vld, 0);
        check("mid_reset_rd_data", rd_data, 0);
        check("mid_reset_rd_err", rd_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        tx_check(16'h0FF0);
        rx_drain("final_drain");
        check("rd_data_after_reset", rd_data,
`ifdef UART_LOOPBACK_EN
              8'hF0
`else
              8'h00
`endif
        );

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
